// File: rtl/alu_arbiter_pkg.sv
// Shared ALU constants, opcode encodings and requester ids for the arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  localparam int RISCV_XLEN     = 32;
  localparam int RISCV_XLEN_EXP = 5;
  localparam int OP_BIT         = 4;

  // Requester ids carried on rsp_id
  localparam logic ARB_ID_EXU = 1'b0;
  localparam logic ARB_ID_AUX = 1'b1;

  // ALU opcode encodings; codes 11..15 are undefined and yield 0
  typedef enum logic [OP_BIT-1:0] {
    ENUM_OP_ADD  = 4'd0,
    ENUM_OP_SUB  = 4'd1,
    ENUM_OP_SLL  = 4'd2,
    ENUM_OP_SLT  = 4'd3,
    ENUM_OP_SLTU = 4'd4,
    ENUM_OP_XOR  = 4'd5,
    ENUM_OP_SRL  = 4'd6,
    ENUM_OP_SRA  = 4'd7,
    ENUM_OP_OR   = 4'd8,
    ENUM_OP_AND  = 4'd9,
    ENUM_OP_ADD0 = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational integer ALU shared by the arbiter's requesters.
// Latency: 0 cycles (result valid in the same cycle as the operands).
// Backpressure: none; no state, no handshake.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = RISCV_XLEN,
  parameter int OPW  = OP_BIT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OPW-1:0]  op,
  output logic [XLEN-1:0] res
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  // Shift amounts only use the low log2(XLEN) bits of B
  assign shamt = b[SHW-1:0];

  // Opcode decode; anything unlisted falls through to zero
  always_comb begin
    res = '0;
    case (op)
      ENUM_OP_ADD:  res = a + b;
      ENUM_OP_SUB:  res = a - b;
      ENUM_OP_SLL:  res = a << shamt;
      ENUM_OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ENUM_OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ENUM_OP_XOR:  res = a ^ b;
      ENUM_OP_SRL:  res = a >> shamt;
      ENUM_OP_SRA:  res = $signed(a) >>> shamt;
      ENUM_OP_OR:   res = a | b;
      ENUM_OP_AND:  res = a & b;
      ENUM_OP_ADD0: res = b;
      default:      res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the EXU (port 0) and an aux client (port 1), round-robin or fixed priority.
// Latency: 1 cycle from request transfer to rsp_valid; one op per cycle while rsp_ready=1.
// Backpressure: a held, unaccepted result blocks both request ports; drain and new accept may overlap.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = RISCV_XLEN,
  parameter int OPW  = OP_BIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_rr,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [OPW-1:0]  req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [OPW-1:0]  req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OPW-1:0]  op;
  } req_t;

  req_t            sel_req;
  logic [1:0]      gnt;
  logic            last_gnt;
  logic            can_accept;
  logic            fire;
  logic            sel_id;
  logic [XLEN-1:0] alu_res;

  // Grant: a lone requester wins; on a tie, rotate in RR mode, else port 0 wins
  always_comb begin
    gnt = 2'b00;
    if (req0_valid && req1_valid) begin
      if (cfg_rr) gnt = last_gnt ? 2'b01 : 2'b10;
      else        gnt = 2'b01;
    end else if (req0_valid) begin
      gnt = 2'b01;
    end else if (req1_valid) begin
      gnt = 2'b10;
    end
  end

  // The output register can take a new result if empty or draining this cycle
  assign can_accept = ~rsp_valid | rsp_ready;
  assign req0_ready = rst_n & gnt[0] & can_accept;
  assign req1_ready = rst_n & gnt[1] & can_accept;
  assign fire       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel_id     = gnt[1] ? ARB_ID_AUX : ARB_ID_EXU;
  assign busy       = rsp_valid | req0_valid | req1_valid;

  // Steer the granted port's operands into the single ALU
  always_comb begin
    sel_req = '0;
    if (gnt[1]) begin
      sel_req.a  = req1_a;
      sel_req.b  = req1_b;
      sel_req.op = req1_op;
    end else begin
      sel_req.a  = req0_a;
      sel_req.b  = req0_b;
      sel_req.op = req0_op;
    end
  end

  alu_arbiter_alu #(
    .XLEN(XLEN),
    .OPW (OPW)
  ) u_alu (
    .a  (sel_req.a),
    .b  (sel_req.b),
    .op (sel_req.op),
    .res(alu_res)
  );

  // Result register and priority pointer; the pointer only moves on a real transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      last_gnt  <= 1'b1;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_res;
      rsp_id    <= sel_id;
      last_gnt  <= sel_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int XLEN = RISCV_XLEN;
  localparam int OPW  = OP_BIT;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_rr;
  logic            req0_valid, req0_ready;
  logic [XLEN-1:0] req0_a, req0_b;
  logic [OPW-1:0]  req0_op;
  logic            req1_valid, req1_ready;
  logic [XLEN-1:0] req1_a, req1_b;
  logic [OPW-1:0]  req1_op;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [XLEN-1:0] rsp_data;
  logic            busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_rr    (cfg_rr),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_rr = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = ENUM_OP_ADD;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = ENUM_OP_ADD;
    settle();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%0h exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got=%0h exp=0", req1_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = ENUM_OP_ADD;
    settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got=%0h exp=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    settle();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got=%0h exp=0", rsp_id); end
    checks++; if (rsp_data !== 32'd12) begin errors++; $display("FAIL single_rsp_data got=%0h exp=c", rsp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%0h exp=1", busy); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'd12) begin errors++; $display("FAIL single_drain_data got=%0h exp=c", rsp_data); end
  endtask

  task automatic test_round_robin();
    // Fresh reset so the first tie goes to port 0 even though port 0 won last
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cfg_rr = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = ENUM_OP_SUB;
    req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = ENUM_OP_SRA;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++; if (req0_ready !== ((i % 2) == 0)) begin errors++; $display("FAIL rr_req0_ready[%0d] got=%0h exp=%0h", i, req0_ready, ((i % 2) == 0)); end
      checks++; if (req1_ready !== ((i % 2) == 1)) begin errors++; $display("FAIL rr_req1_ready[%0d] got=%0h exp=%0h", i, req1_ready, ((i % 2) == 1)); end
      step();
      checks++; if (rsp_id !== 1'((i % 2))) begin errors++; $display("FAIL rr_rsp_id[%0d] got=%0h exp=%0h", i, rsp_id, (i % 2)); end
      checks++; if (rsp_data !== (((i % 2) == 0) ? 32'd7 : 32'hF800_0000)) begin errors++; $display("FAIL rr_rsp_data[%0d] got=%0h exp=%0h", i, rsp_data, (((i % 2) == 0) ? 32'd7 : 32'hF800_0000)); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_fixed_priority();
    cfg_rr = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'hFF; req0_op = ENUM_OP_XOR;
    req1_valid = 1'b1; req1_a = 32'h100; req1_b = 32'h1; req1_op = ENUM_OP_OR;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL fp_req1_ready[%0d] got=%0h exp=0", i, req1_ready); end
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL fp_req0_ready[%0d] got=%0h exp=1", i, req0_ready); end
      step();
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL fp_rsp_id[%0d] got=%0h exp=0", i, rsp_id); end
      checks++; if (rsp_data !== 32'h0F) begin errors++; $display("FAIL fp_rsp_data[%0d] got=%0h exp=f", i, rsp_data); end
    end
    req0_valid = 1'b0;
    settle();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL fp_release_req1_ready got=%0h exp=1", req1_ready); end
    step();
    req1_valid = 1'b0;
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL fp_release_rsp_id got=%0h exp=1", rsp_id); end
    checks++; if (rsp_data !== 32'h101) begin errors++; $display("FAIL fp_release_rsp_data got=%0h exp=101", rsp_data); end
  endtask

  task automatic test_backpressure();
    cfg_rr = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'hFFFF_FFFF; req0_op = ENUM_OP_SLTU;
    settle();
    step();
    checks++; if (rsp_data !== 32'd1) begin errors++; $display("FAIL bp_sltu_data got=%0h exp=1", rsp_data); end
    // Port 0 just won, so port 1 is next in line; blocked grants must not rotate
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'h55; req1_op = ENUM_OP_ADD0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready[%0d] got=%0h exp=0", i, req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_ready[%0d] got=%0h exp=0", i, req1_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%0h exp=1", i, rsp_valid); end
      checks++; if (rsp_data !== 32'd1) begin errors++; $display("FAIL bp_hold_data[%0d] got=%0h exp=1", i, rsp_data); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL bp_hold_id[%0d] got=%0h exp=0", i, rsp_id); end
    end
    rsp_ready = 1'b1;
    settle();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req1_ready got=%0h exp=1", req1_ready); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_release_req0_ready got=%0h exp=0", req0_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_overlap_valid got=%0h exp=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL bp_overlap_id got=%0h exp=1", rsp_id); end
    checks++; if (rsp_data !== 32'h55) begin errors++; $display("FAIL bp_overlap_data got=%0h exp=55", rsp_data); end
    req1_valid = 1'b0;
    settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_next_req0_ready got=%0h exp=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL bp_next_id got=%0h exp=0", rsp_id); end
    checks++; if (rsp_data !== 32'd1) begin errors++; $display("FAIL bp_next_data got=%0h exp=1", rsp_data); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got=%0h exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = ENUM_OP_ADD;
    step();
    req1_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL rm_held_id got=%0h exp=1", rsp_id); end
    checks++; if (rsp_data !== 32'd7) begin errors++; $display("FAIL rm_held_data got=%0h exp=7", rsp_data); end
    rst_n = 1'b0; cfg_rr = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hFF; req0_b = 32'h0F; req0_op = ENUM_OP_AND;
    req1_valid = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rm_req0_ready got=%0h exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rm_req1_ready got=%0h exp=0", req1_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid got=%0h exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL rm_rsp_data got=%0h exp=0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rm_rsp_id got=%0h exp=0", rsp_id); end
    rst_n = 1'b1; rsp_ready = 1'b1;
    settle();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rm_tie_req0_ready got=%0h exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rm_tie_req1_ready got=%0h exp=0", req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL rm_tie_id got=%0h exp=0", rsp_id); end
    checks++; if (rsp_data !== 32'h0F) begin errors++; $display("FAIL rm_tie_data got=%0h exp=f", rsp_data); end
    step();
  endtask

  task automatic test_ops();
    logic [OPW-1:0]  t_op[6];
    logic [XLEN-1:0] t_a[6];
    logic [XLEN-1:0] t_b[6];
    logic [XLEN-1:0] t_exp[6];
    t_op  = '{4'hF,  ENUM_OP_SLT,   ENUM_OP_SLL, ENUM_OP_SRL,   ENUM_OP_ADD0, ENUM_OP_SLTU};
    t_a   = '{32'd5, 32'h8000_0000, 32'd1,       32'h8000_0000, 32'd9,        32'hFFFF_FFFF};
    t_b   = '{32'd3, 32'd1,         32'h21,      32'd4,         32'h1234,     32'd1};
    t_exp = '{32'd0, 32'd1,         32'd2,       32'h0800_0000, 32'h1234,     32'd0};
    rsp_ready = 1'b1; cfg_rr = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_op = t_op[i]; req0_a = t_a[i]; req0_b = t_b[i];
      settle();
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL ops_req0_ready[%0d] got=%0h exp=1", i, req0_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ops_rsp_valid[%0d] got=%0h exp=1", i, rsp_valid); end
      checks++; if (rsp_data !== t_exp[i]) begin errors++; $display("FAIL ops_rsp_data[%0d] got=%0h exp=%0h", i, rsp_data, t_exp[i]); end
    end
    req0_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ops_drain_valid got=%0h exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ops_idle_busy got=%0h exp=0", busy); end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_reset_mid();
    test_ops();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
